// File: rtl/maxpool_sched.sv
// maxpool_sched: 2x2, stride-2 max-pool sequencer between the conv-result
// memory and the pooled-feature buffer.
// Optional build macro MAXPOOL_RELU_EN: clamps negative maxima to 0 (fused ReLU).
// Pipeline: p0 = address/ren, p1 = memory data valid, p2 = registered max/write.
module maxpool_sched #(
  parameter int N_C        = 26,
  parameter int N_R        = 26,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int OUT_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_ren,
  output logic [ADDR_W-1:0]     mem_radd1,
  output logic [ADDR_W-1:0]     mem_radd2,
  input  logic [DATA_W-1:0]     mem_rdata0,
  input  logic [DATA_W-1:0]     mem_rdata1,
  input  logic [DATA_W-1:0]     mem_rdata2,
  input  logic [DATA_W-1:0]     mem_rdata3,
  output logic                  pool_wen,
  output logic [OUT_ADDR_W-1:0] pool_wadd,
  output logic [DATA_W-1:0]     pool_wdata
);

  // Top-left corner of the last complete window; an odd trailing row/column is skipped.
  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'((N_C / 2 - 1) * 2);
  localparam logic [ADDR_W-1:0] LAST_R = ADDR_W'((N_R / 2 - 1) * 2);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic [ADDR_W-1:0]        row_p0, col_p0;
  logic                     drain_cnt;
  logic                     last_win;
  logic                     accept;
  logic                     vld_p1;
  logic [OUT_ADDR_W-1:0]    wr_cnt;
  logic signed [DATA_W-1:0] max_p1;
  logic signed [DATA_W-1:0] wr_val_p1;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

`ifdef MAXPOOL_RELU_EN
  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] a);
    return (a < 0) ? '0 : a;
  endfunction
`endif

  // A start landing on the done cycle is deliberately dropped.
  assign accept   = (state == IDLE) && start && !done;
  assign last_win = (row_p0 == LAST_R) && (col_p0 == LAST_C);

  // State register plus drain counter and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      done      <= (state == DRAIN) && drain_cnt;
    end
  end

  // Next-state decode and control outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    mem_ren   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        mem_ren = 1'b1;
        if (last_win) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: window walk; counters freeze on the last window so the address holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_p0 <= '0;
      col_p0 <= '0;
    end else if (accept) begin
      row_p0 <= '0;
      col_p0 <= '0;
    end else if (state == RUN && !last_win) begin
      if (col_p0 == LAST_C) begin
        col_p0 <= '0;
        row_p0 <= row_p0 + STEP;
      end else begin
        col_p0 <= col_p0 + STEP;
      end
    end
  end

  assign mem_radd1 = row_p0;
  assign mem_radd2 = col_p0;

  // ---- stage p1: memory has registered the window; track its validity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= mem_ren;
  end

  // Two-level signed compare tree over the returned window.
  always_comb begin
    max_p1 = smax(smax(mem_rdata0, mem_rdata1), smax(mem_rdata2, mem_rdata3));
`ifdef MAXPOOL_RELU_EN
    wr_val_p1 = relu(max_p1);
`else
    wr_val_p1 = max_p1;
`endif
  end

  // ---- stage p2: register the pooled value and its row-major address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pool_wen   <= 1'b0;
      pool_wadd  <= '0;
      pool_wdata <= '0;
      wr_cnt     <= '0;
    end else begin
      pool_wen <= vld_p1;
      if (accept)      wr_cnt <= '0;
      else if (vld_p1) wr_cnt <= wr_cnt + OUT_ADDR_W'(1);
      if (vld_p1) begin
        pool_wadd  <= wr_cnt;
        pool_wdata <= wr_val_p1;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_sched.sv
// Scoreboard bench for maxpool_sched: default 26x26 instance plus a 5x5 instance.
module tb_maxpool_sched;

  localparam int W = 169;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic       busy, done, mem_ren, pool_wen;
  logic [9:0] mem_radd1, mem_radd2;
  logic [7:0] rd0, rd1, rd2, rd3;
  logic [7:0] pool_wadd, pool_wdata;

  logic       start5, busy5, done5, ren5, wen5;
  logic [9:0] r5, c5;
  logic [7:0] d5_0, d5_1, d5_2, d5_3;
  logic [7:0] wadd5, wdata5;

  maxpool_sched dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_ren(mem_ren), .mem_radd1(mem_radd1), .mem_radd2(mem_radd2),
    .mem_rdata0(rd0), .mem_rdata1(rd1), .mem_rdata2(rd2), .mem_rdata3(rd3),
    .pool_wen(pool_wen), .pool_wadd(pool_wadd), .pool_wdata(pool_wdata)
  );

  maxpool_sched #(.N_C(5), .N_R(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .busy(busy5), .done(done5),
    .mem_ren(ren5), .mem_radd1(r5), .mem_radd2(c5),
    .mem_rdata0(d5_0), .mem_rdata1(d5_1), .mem_rdata2(d5_2), .mem_rdata3(d5_3),
    .pool_wen(wen5), .pool_wadd(wadd5), .pool_wdata(wdata5)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  exp_t       sb5[$];
  logic [7:0] img [0:25][0:25];
  logic [7:0] obs [0:255];
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_done = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endfunction

  // Conv-result memory model: registered 2x2 window read.
  always @(posedge clk) begin
    if (mem_ren) begin
      rd0 <= img[mem_radd1][mem_radd2];
      rd1 <= img[mem_radd1][mem_radd2 + 10'd1];
      rd2 <= img[mem_radd1 + 10'd1][mem_radd2];
      rd3 <= img[mem_radd1 + 10'd1][mem_radd2 + 10'd1];
    end
  end

  // 5x5 memory model: pixel = r*5 + c.
  always @(posedge clk) begin
    if (ren5) begin
      d5_0 <= 8'(int'(r5) * 5 + int'(c5));
      d5_1 <= 8'(int'(r5) * 5 + int'(c5) + 1);
      d5_2 <= 8'((int'(r5) + 1) * 5 + int'(c5));
      d5_3 <= 8'((int'(r5) + 1) * 5 + int'(c5) + 1);
    end
  end

  // Monitors: pop and compare on every write strobe.
  always @(negedge clk) begin
    exp_t e;
    if (pool_wen) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", pool_wadd, pool_wdata);
      end else begin
        e = sb.pop_front();
        chk("write", {pool_wadd, pool_wdata}, {e.a, e.d});
      end
      obs[pool_wadd] = pool_wdata;
    end
    if (done) n_done++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (wen5) begin
      if (sb5.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write5: got addr %0d data %0d, expected no write", wadd5, wdata5);
      end else begin
        e = sb5.pop_front();
        chk("write5", {wadd5, wdata5}, {e.a, e.d});
      end
    end
  end

  function automatic logic [7:0] exp_val(input int r, input int c);
    logic signed [7:0] m;
    m = img[r][c];
    if ($signed(img[r][c+1])   > m) m = img[r][c+1];
    if ($signed(img[r+1][c])   > m) m = img[r+1][c];
    if ($signed(img[r+1][c+1]) > m) m = img[r+1][c+1];
`ifdef MAXPOOL_RELU_EN
    if (m < 0) m = '0;
`endif
    return m;
  endfunction

  task automatic push_pass();
    for (int k = 0; k < W; k++)
      sb.push_back('{a: 8'(k), d: exp_val(2 * (k / 13), 2 * (k % 13))});
  endtask

  task automatic set_ramp();
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++)
        img[r][c] = 8'((r * 26 + c) % 128);
  endtask

  // Every pixel -5, one -1 per window rotating through all four positions.
  task automatic set_neg();
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++)
        img[r][c] = 8'hFB;
    for (int k = 0; k < W; k++)
      img[2 * (k / 13) + (k % 4) / 2][2 * (k % 13) + (k % 4) % 2] = 8'hFF;
  endtask

  // Runs one pass; optionally re-pulses start at cycles 10 and 172.
  task automatic run_pass(input bit extra, input string tag);
    int cyc, ren, wen, fr, lr, fw, lw, dc;
    logic busy_at_done;
    ren = 0; wen = 0; fr = 0; lr = 0; fw = 0; lw = 0; dc = 0; busy_at_done = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      if (mem_ren) begin ren++; lr = cyc; if (fr == 0) fr = cyc; end
      if (pool_wen) begin wen++; lw = cyc; if (fw == 0) fw = cyc; end
      start = extra && (cyc == 10 || cyc == 172);
      if (done) begin dc = cyc; busy_at_done = busy; break; end
      @(posedge clk); #1;
      cyc++;
    end
    if (start) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk({tag, "_done_cycle"}, dc, 172);
    chk({tag, "_ren_count"}, ren, W);
    chk({tag, "_ren_span"}, {fr[15:0], lr[15:0]}, {16'd1, 16'd169});
    chk({tag, "_wen_count"}, wen, W);
    chk({tag, "_wen_span"}, {fw[15:0], lw[15:0]}, {16'd3, 16'd171});
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, cyc, n, dc, wen_seen;
    logic [9:0] er [4];
    logic [9:0] ec [4];
    rst = 1'b1; start = 1'b0; start5 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, mem_ren, pool_wen, mem_radd1, mem_radd2, pool_wadd, pool_wdata}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ramp map.
    set_ramp();
    push_pass();
    run_pass(1'b0, "ramp");
    repeat (3) @(posedge clk);
    #1;
    chk("ramp_win0", obs[0], 27);
    chk("ramp_win13", obs[13], 79);
    chk("ramp_last_addr", pool_wadd, 168);
    chk("ramp_sb_empty", sb.size(), 0);

    // All-negative map.
    set_neg();
    push_pass();
    run_pass(1'b0, "neg");
    repeat (3) @(posedge clk);
    #1;
`ifdef MAXPOOL_RELU_EN
    chk("neg_first", obs[0], 8'h00);
    chk("neg_last", obs[168], 8'h00);
`else
    chk("neg_first", obs[0], 8'hFF);
    chk("neg_last", obs[168], 8'hFF);
`endif

    // Start re-pulsed mid-pass and on the done cycle.
    set_ramp();
    push_pass();
    n0 = n_done;
    run_pass(1'b1, "restart");
    repeat (5) @(posedge clk);
    #1;
    chk("restart_idle", {busy, mem_ren}, 0);
    chk("restart_one_done", n_done - n0, 1);
    chk("restart_sb_empty", sb.size(), 0);

    // Asynchronous reset at cycle 50.
    push_pass();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset", {busy, done, mem_ren, pool_wen, mem_radd1, mem_radd2, pool_wadd, pool_wdata}, 0);
    wen_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (pool_wen) wen_seen++;
    end
    chk("no_wen_in_reset", wen_seen, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    push_pass();
    run_pass(1'b0, "after_rst");
    repeat (3) @(posedge clk);
    #1;
    chk("after_rst_win0", obs[0], 27);

    // Back-to-back passes.
    push_pass();
    run_pass(1'b0, "b2b_a");
    @(posedge clk); #1;
    push_pass();
    run_pass(1'b0, "b2b_b");
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_sb_empty", sb.size(), 0);

    // 5x5 instance: windows (0,0),(0,2),(2,0),(2,2); maxima 6, 8, 16, 18.
    er = '{10'd0, 10'd0, 10'd2, 10'd2};
    ec = '{10'd0, 10'd2, 10'd0, 10'd2};
    sb5.push_back('{a: 8'd0, d: 8'd6});
    sb5.push_back('{a: 8'd1, d: 8'd8});
    sb5.push_back('{a: 8'd2, d: 8'd16});
    sb5.push_back('{a: 8'd3, d: 8'd18});
    start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    cyc = 1; n = 0; dc = 0;
    while (cyc < 50) begin
      if (ren5) begin
        if (n < 4) chk("w5_addr", {r5, c5}, {er[n], ec[n]});
        n++;
      end
      if (done5) begin dc = cyc; break; end
      @(posedge clk); #1;
      cyc++;
    end
    chk("w5_windows", n, 4);
    chk("w5_done_cycle", dc, 7);
    repeat (3) @(posedge clk);
    #1;
    chk("w5_sb_empty", sb5.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/maxpool_sched.md
# maxpool_sched

Sequencer that walks a 2x2, stride-2 max-pool over the convolution result memory. It issues row/column read addresses to that memory, takes the four registered window pixels it returns, and writes the signed maximum to the pooled-feature buffer. It also raises a completion pulse to the layer controller. It sits between the conv-result memory and the next layer's input buffer, one instance per feature map.

## Interface
Parameters:
- N_C, 26, columns of conv-result image
- N_R, 26, rows of conv-result image
- ADDR_W, 10, width of memory row/column index ports
- DATA_W, 8, pixel width, signed two's complement
- OUT_ADDR_W, 8, pooled-buffer address width; must hold (N_R/2)*(N_C/2)-1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to pool one full map
- busy  out  1  high while a pass is in progress
- done  out  1  one-cycle pulse at end of pass
- mem_ren  out  1  read enable to conv-result memory
- mem_radd1  out  ADDR_W  window top-left row index
- mem_radd2  out  ADDR_W  window top-left column index
- mem_rdata0..mem_rdata3  in  DATA_W each  window pixels (r,c), (r,c+1), (r+1,c), (r+1,c+1), registered by memory
- pool_wen  out  1  pooled-buffer write strobe
- pool_wadd  out  OUT_ADDR_W  pooled-buffer address, row-major
- pool_wdata  out  DATA_W  pooled value, signed

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start=1 moves to RUN and clears row/col/output counters.
  - RUN: one window per cycle. Column steps +2; on the last full window column it wraps to 0 and the row steps +2. Leaving the last window moves to DRAIN.
  - DRAIN: holds 2 cycles to flush the pipeline, then pulses done and returns to IDLE.
- Window count is floor(N_R/2)*floor(N_C/2), 169 at defaults. An odd trailing row or column is never read.
- Max uses a signed compare tree, two levels of pairwise max. On a tie either operand is taken (same value).
- pool_wadd starts at 0 and increments by 1 per write.
- Pipeline is 3 stages:
  1. Address/ren.
  2. Memory returns data; valid_d1 tracks it.
  3. Max is registered into pool_wdata together with pool_wen.
- start is ignored while busy=1. A start on the same cycle done pulses is also ignored.
- Reset, including mid-pass, clears to IDLE:
  - busy, done, mem_ren, pool_wen, mem_radd1, mem_radd2, pool_wadd, pool_wdata all 0.
  - Any in-flight window is discarded with no partial write.

## Timing
- Start sampled at edge E0:
  - busy and mem_ren go high after E0.
  - mem_ren stays high for exactly W consecutive cycles (W = window count).
- Address (r,c) is presented in the same cycle as its mem_ren.
- Latency from mem_ren to pool_wen is 2 cycles. pool_wen is high for W consecutive cycles; first write at cycle 3, last at cycle W+2.
- done is high for 1 cycle at cycle W+3. busy falls together with done.
- Total pass at defaults: start edge to done is 172 cycles.
- mem_radd1 and mem_radd2 hold their last value when mem_ren=0. pool_wdata holds its last value when pool_wen=0.

## Configuration
- MAXPOOL_RELU_EN defined: the registered max is clamped, so negative results write 0. This fuses ReLU into pooling.
- MAXPOOL_RELU_EN undefined: the raw signed max is written, including negatives.
- Latency and handshakes are identical in both builds.

## Test plan
- Ramp map (pixel = (r*26+c) mod 128), one start:
  - Expect 169 writes; pool_wadd runs 0..168.
  - Window (0,0) writes 27; write at address 13 is from window (2,0), value 79.
  - done arrives exactly 172 cycles after start.
- All-negative map (every pixel -5, one pixel -1 per window at a rotating position):
  - Expect every write = -1 (0xFF) with the macro undefined, 0 with MAXPOOL_RELU_EN.
  - Coverage goal: every rdata position wins at least once.
- Start pulsed again at cycles 10 and 172 (the done cycle) of a pass → ignored. Exactly 169 writes and one done pulse.
- rst asserted at cycle 50 of a pass:
  - All outputs are 0 within the same cycle (async).
  - No pool_wen while rst is high.
  - A following start completes a clean 169-write pass from pool_wadd=0.
- Back-to-back passes (start the cycle after done) → second pass timing is identical to the first, no overlap of pool_wen.
- N_C=N_R=5 build → 4 windows, at (0,0), (0,2), (2,0), (2,2). Row 4 and column 4 are never addressed; done at cycle 7.
